flopoco_to_ieee_arbiter: RTL and testbench
==========================================

# flopoco_to_ieee_arbiter

Round-robin arbiter that shares one `flopoco_to_ieee_sp` converter among `NUM_REQ` requesters, each presenting 34-bit FloPoCo single-precision values over valid/ready. Results leave through a single registered valid/ready output, tagged with the originating requester index. Sticky NaN/Inf status flags are kept for the host. The block sits between the FloPoCo arithmetic lanes and the IEEE-754 writeback/AXI side.

## Interface
- `NUM_REQ`, 4, number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`, width of the requester tag, derived and not overridden.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_ready`  out  NUM_REQ  per-requester ready; at most one bit high per cycle.
- `req_data`  in  NUM_REQ*34  requester i occupies bits [34*i+33 : 34*i], FloPoCo format {exn[1:0], sign, exp[7:0], frac[22:0]}.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  32  IEEE-754 single result.
- `out_id`  out  ID_W  index of the requester that produced `out_data`.
- `out_exn`  out  2  exn field of the source operand.
- `flag_clear`  in  1  clears both sticky flags.
- `flag_nan`  out  1  sticky: a result with exn=11 was loaded.
- `flag_inf`  out  1  sticky: a result with exn=10 was loaded.

## Operation
- Output stage: a register holding {out_data, out_id, out_exn}, with out_valid as its full bit.
- `can_load` = !out_valid | out_ready.
- Arbitration: round-robin over requesters with req_valid high.
  - The search starts at index `ptr`, then ptr+1, ..., wrapping modulo NUM_REQ.
  - Winner `g` is the first valid requester found.
  - `ptr` resets to 0.
  - On every transfer, `ptr` becomes (g+1) mod NUM_REQ. With no transfer, `ptr` holds.
- `req_ready[g]` = can_load when any req_valid is high; all other bits are 0.
  - req_ready depends combinationally on req_valid, ptr, out_valid and out_ready.
  - It is 0 for every requester while none is valid.
- Transfer = req_valid[g] & req_ready[g].
  - On a transfer, the register loads the converter output for req_data[g], plus g and its exn.
  - out_valid is set.
- Drain: if out_valid & out_ready and there is no transfer that cycle, out_valid clears.
- Simultaneous drain and load: the new result replaces the old one back-to-back, giving one result per cycle of throughput.
- Conversion is the combinational `flopoco_to_ieee_sp` function:
  - exn=00 gives {s,8'h00,23'h0}, with the sign kept.
  - exn=01 with exp≠0 gives {s,exp,frac}.
  - exn=01 with exp=0 gives {s,8'h00,1'b1,frac[22:1]}.
  - exn=10 gives {s,8'hFF,23'h0}.
  - exn=11 gives {1'b0,8'hFF,23'h1}.
- Requesters must hold req_valid/req_data stable until accepted. The block does not check this.
- Flags:
  - flag_nan sets when a transfer loads exn=11; flag_inf sets when a transfer loads exn=10.
  - flag_clear zeroes both flags.
  - A set in the same cycle as flag_clear wins, so the flag stays 1.

## Timing
- Reset (async assert, sync-safe deassert expected upstream): out_valid=0, out_data=0, out_id=0, out_exn=0, flag_nan=0, flag_inf=0, ptr=0.
  - req_ready is 0 because no requester is valid during reset.
- Mid-operation reset discards any held result. The first grant after reset goes to the lowest valid index.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 result/cycle when out_ready is held high.
- Backpressure: with out_valid=1 and out_ready=0, all req_ready are 0.
  - out_data, out_id and out_exn are stable.
  - ptr does not advance.
- Fairness: with all requesters continuously valid and no backpressure, each requester is granted exactly once in every NUM_REQ consecutive transfers.
- No combinational path from out_ready to out_valid/out_data. The path out_ready→req_ready is combinational.

## Test plan
- Single transfer: req 2 sends {01,0,8'h7F,23'h0}, out_ready=1.
  - Next cycle: out_valid=1, out_data=32'h3F800000, out_id=2, out_exn=01.
  - Following cycle: out_valid=0.
- Encodings through req 0, one per cycle:
  - exn01 exp0 frac 23'h400000 → 32'h00600000.
  - exn00 s=1 → 32'h80000000.
  - exn10 s=1 → 32'hFF800000, and flag_inf=1.
  - exn11 s=1 → 32'h7F800001, and flag_nan=1.
- Round-robin: all four requesters valid continuously, out_ready=1 → out_id sequence 0,1,2,3,0,1.
  - Then drop req 1: sequence 2,3,0,2,3,0.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1.
  - out_data and out_id are unchanged.
  - req_ready=0000.
  - On release, the next grant continues from the pointer without skipping any requester.
- Flags: flag_clear asserted in the same cycle as a NaN load → flag_nan remains 1. A later lone flag_clear → 0.
- Reset mid-stream: assert rst_n=0 while out_valid=1.
  - All outputs go to 0 immediately.
  - After release, with reqs 1 and 3 valid, req 1 is granted first.

Source files
------------

// File: rtl/flopoco_to_ieee_arbiter_if.sv
// rtl/flopoco_to_ieee_arbiter_if.sv - requester and result handshake bundle for the FloPoCo-to-IEEE arbiter
interface flopoco_to_ieee_arbiter_if #(
   parameter int NUM_REQ = 4,
   localparam int ID_W = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*34-1:0] req_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           out_data;
   logic [ID_W-1:0]       out_id;
   logic [1:0]            out_exn;

   // master: requesters plus the downstream consumer; slave: the arbiter
   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, out_exn
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, out_exn
   );
endinterface

// File: rtl/flopoco_to_ieee_arbiter.sv
// rtl/flopoco_to_ieee_arbiter.sv - round-robin share of one FloPoCo-to-IEEE single converter
module flopoco_to_ieee_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int ID_W = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   flopoco_to_ieee_arbiter_if.slave   bus,
   input  logic                       flag_clear,
   output logic                       flag_nan,
   output logic                       flag_inf
);

   function automatic logic [31:0] flopocoToIeee(input logic [33:0] x);
      logic [31:0] r;
      case (x[33:32])
         2'b00:   r = {x[31], 31'h0};
         2'b01:   r = (x[30:23] != 8'h00) ? x[31:0] : {x[31], 8'h00, 1'b1, x[22:1]};
         2'b10:   r = {x[31], 8'hFF, 23'h0};
         default: r = {1'b0, 8'hFF, 23'h1};
      endcase
      return r;
   endfunction

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] grant;
   logic            anyValid;
   logic            canLoad;
   logic            xfer;
   logic [33:0]     selData;
   int              idx;

   assign canLoad = !bus.out_valid || bus.out_ready;
   assign xfer    = anyValid && canLoad;
   assign selData = bus.req_data[int'(grant)*34 +: 34];

   // Scan offsets from the far end so the one closest to ptr overwrites last and wins.
   always_comb begin
      grant    = '0;
      anyValid = 1'b0;
      idx      = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (bus.req_valid[idx]) begin
            grant    = ID_W'(idx);
            anyValid = 1'b1;
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (xfer) bus.req_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr           <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= 32'h0;
         bus.out_id    <= '0;
         bus.out_exn   <= 2'b00;
         flag_nan      <= 1'b0;
         flag_inf      <= 1'b0;
      end else begin
         if (xfer) begin
            ptr           <= ID_W'((int'(grant) + 1) % NUM_REQ);
            bus.out_valid <= 1'b1;
            bus.out_data  <= flopocoToIeee(selData);
            bus.out_id    <= grant;
            bus.out_exn   <= selData[33:32];
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         // A set in the same cycle as a clear takes priority.
         flag_nan <= (flag_nan && !flag_clear) || (xfer && selData[33:32] == 2'b11);
         flag_inf <= (flag_inf && !flag_clear) || (xfer && selData[33:32] == 2'b10);
      end
   end

endmodule

// File: tb/tb_flopoco_to_ieee_arbiter.sv
// tb/tb_flopoco_to_ieee_arbiter.sv - directed self-checking bench for the FloPoCo-to-IEEE arbiter
module tb_flopoco_to_ieee_arbiter;
   localparam int NUM_REQ = 4;

   logic clk;
   logic rst_n;
   logic flag_clear;
   logic flag_nan;
   logic flag_inf;
   int   vectors;
   int   miscompares;

   flopoco_to_ieee_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   flopoco_to_ieee_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .flag_clear (flag_clear),
      .flag_nan   (flag_nan),
      .flag_inf   (flag_inf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic setLane(input int i, input logic [33:0] v);
      bus.req_data[34*i +: 34] = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [33:0] encIn  [4];
   logic [31:0] encOut [4];
   int          rrExp  [6];
   int          rrExp2 [6];

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst_n         = 1'b0;
      flag_clear    = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 34'(bus.out_valid), 34'd0);
      chk("rst_out_data",  34'(bus.out_data),  34'd0);
      chk("rst_out_id",    34'(bus.out_id),    34'd0);
      chk("rst_out_exn",   34'(bus.out_exn),   34'd0);
      chk("rst_flag_nan",  34'(flag_nan),      34'd0);
      chk("rst_flag_inf",  34'(flag_inf),      34'd0);
      chk("rst_req_ready", 34'(bus.req_ready), 34'd0);
      rst_n = 1'b1;
      #2;

      // Single transfer from requester 2 (1.0)
      setLane(2, {2'b01, 1'b0, 8'h7F, 23'h0});
      bus.req_valid = 4'b0100;
      #1;
      chk("single_req_ready", 34'(bus.req_ready), 34'b0100);
      step();
      bus.req_valid = '0;
      chk("single_valid", 34'(bus.out_valid), 34'd1);
      chk("single_data",  34'(bus.out_data),  34'h3F800000);
      chk("single_id",    34'(bus.out_id),    34'd2);
      chk("single_exn",   34'(bus.out_exn),   34'b01);
      step();
      chk("single_drain", 34'(bus.out_valid), 34'd0);

      // Encodings through requester 0, one per cycle
      encIn[0] = {2'b01, 1'b0, 8'h00, 23'h400000}; encOut[0] = 32'h00600000;
      encIn[1] = {2'b00, 1'b1, 8'h55, 23'h123456}; encOut[1] = 32'h80000000;
      encIn[2] = {2'b10, 1'b1, 8'h12, 23'h000001}; encOut[2] = 32'hFF800000;
      encIn[3] = {2'b11, 1'b1, 8'h34, 23'h7FFFFF}; encOut[3] = 32'h7F800001;
      bus.req_valid = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         setLane(0, encIn[i]);
         step();
         chk($sformatf("enc%0d_data", i), 34'(bus.out_data), 34'(encOut[i]));
         chk($sformatf("enc%0d_exn", i),  34'(bus.out_exn),  34'(encIn[i][33:32]));
         if (i == 2) chk("enc_flag_inf", 34'(flag_inf), 34'd1);
         if (i == 3) chk("enc_flag_nan", 34'(flag_nan), 34'd1);
      end
      bus.req_valid = '0;
      step();

      // Park the pointer at 0 via requester 3, then all four valid
      for (int i = 0; i < 4; i++) setLane(i, {2'b01, 1'b0, 8'(8'h80 + i), 23'h0});
      bus.req_valid = 4'b1000;
      step();
      chk("rr_park_id", 34'(bus.out_id), 34'd3);
      rrExp  = '{0, 1, 2, 3, 0, 1};
      rrExp2 = '{2, 3, 0, 2, 3, 0};
      bus.req_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("rr_all_id%0d", i), 34'(bus.out_id), 34'(rrExp[i]));
      end
      bus.req_valid = 4'b1101;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("rr_drop1_id%0d", i), 34'(bus.out_id), 34'(rrExp2[i]));
      end
      chk("rr_last_data", 34'(bus.out_data), 34'h40000000);

      // Backpressure holding requester 0's result
      bus.out_ready = 1'b0;
      #1;
      chk("bp_req_ready", 34'(bus.req_ready), 34'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("bp_valid%0d", i), 34'(bus.out_valid), 34'd1);
         chk($sformatf("bp_data%0d", i),  34'(bus.out_data),  34'h40000000);
         chk($sformatf("bp_id%0d", i),    34'(bus.out_id),    34'd0);
         chk($sformatf("bp_ready%0d", i), 34'(bus.req_ready), 34'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 34'(bus.req_ready), 34'b0100);
      step();
      chk("bp_release_id",   34'(bus.out_id),   34'd2);
      chk("bp_release_data", 34'(bus.out_data), 34'h41000000);
      bus.req_valid = '0;
      step();

      // Flags: lone clear, clear colliding with a NaN load, lone clear again
      flag_clear = 1'b1;
      step();
      chk("clr_flag_nan", 34'(flag_nan), 34'd0);
      chk("clr_flag_inf", 34'(flag_inf), 34'd0);
      setLane(3, {2'b11, 1'b0, 8'h00, 23'h0});
      bus.req_valid = 4'b1000;
      step();
      bus.req_valid = '0;
      chk("nan_vs_clear",  34'(flag_nan), 34'd1);
      chk("nan_vs_clr_id", 34'(bus.out_id), 34'd3);
      step();
      chk("late_clear_nan", 34'(flag_nan), 34'd0);
      flag_clear = 1'b0;

      // Reset while a result is held
      setLane(0, {2'b01, 1'b0, 8'h81, 23'h1});
      bus.req_valid = 4'b0001;
      bus.out_ready = 1'b0;
      step();
      chk("pre_rst_valid", 34'(bus.out_valid), 34'd1);
      bus.req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 34'(bus.out_valid), 34'd0);
      chk("mid_rst_data",  34'(bus.out_data),  34'd0);
      chk("mid_rst_id",    34'(bus.out_id),    34'd0);
      chk("mid_rst_exn",   34'(bus.out_exn),   34'd0);
      bus.out_ready = 1'b1;
      bus.req_valid = 4'b1010;
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 34'(bus.req_ready), 34'b0010);
      step();
      chk("post_rst_id",   34'(bus.out_id),   34'd1);
      chk("post_rst_data", 34'(bus.out_data), 34'h40800000);
      bus.req_valid = '0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
